// File: rtl/snake_pkg.sv
// snake_pkg: grid geometry, cell codes and arbiter FSM states shared by the snake grid blocks
package snake_pkg;
  localparam int GRID_W = 40;
  localparam int GRID_H = 30;
  localparam int CELL_PX = 20;
  localparam int ADDR_W = 11;
  typedef logic [1:0] cell_t;
  localparam cell_t CELL_EMPTY = 2'd0;
  localparam cell_t CELL_BODY = 2'd1;
  localparam cell_t CELL_HEAD = 2'd2;
  localparam cell_t CELL_FOOD = 2'd3;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
endpackage

// File: rtl/snake_grid_arbiter_if.sv
// snake_grid_arbiter_if: display, game-port and grid RAM signals around snake_grid_arbiter
interface snake_grid_arbiter_if;
  import snake_pkg::*;
  logic vsync, pix_valid, cell_valid, pix_border;
  logic g_req, g_we, g_gnt, g_rvalid, ram_we;
  cell_t cell_code, g_wdata, g_rdata, ram_wdata, ram_rdata;
  logic [ADDR_W-1:0] g_addr, ram_addr;
  modport slave (
    input vsync, pix_valid, g_req, g_we, g_addr, g_wdata, ram_rdata,
    output cell_code, cell_valid, pix_border, g_gnt, g_rdata, g_rvalid, ram_addr, ram_we, ram_wdata
  );
  modport master (
    output vsync, pix_valid, g_req, g_we, g_addr, g_wdata, ram_rdata,
    input cell_code, cell_valid, pix_border, g_gnt, g_rdata, g_rvalid, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/snake_line_buf.sv
// snake_line_buf: one-row cell register file, one write port and one asynchronous read port
module snake_line_buf import snake_pkg::*; #(
  parameter int DEPTH = GRID_W,
  localparam int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst_n,
  input logic i_we,
  input logic [AW-1:0] i_waddr,
  input cell_t i_wdata,
  input logic [AW-1:0] i_raddr,
  output cell_t o_rdata
);
  cell_t r_mem [DEPTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_mem <= '{default: CELL_EMPTY};
    else if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/snake_grid_arbiter.sv
// snake_grid_arbiter: grid RAM shared by blanking-time row fetch and game port; `GRID_BORDER_EN builds pix_border
module snake_grid_arbiter #(
  parameter int GRID_W = snake_pkg::GRID_W,
  parameter int GRID_H = snake_pkg::GRID_H,
  parameter int CELL_PX = snake_pkg::CELL_PX
) (
  input logic clk,
  input logic rst_n,
  snake_grid_arbiter_if.slave bus
);
  import snake_pkg::*;
  localparam int CW = $clog2(GRID_W);
  localparam int RW = $clog2(GRID_H);
  localparam int SW = $clog2(CELL_PX);
  state_t r_state;
  logic [CW-1:0] r_k, r_col;
  logic [RW-1:0] r_row;
  logic [SW-1:0] r_sub, r_line;
  logic [ADDR_W-1:0] r_base;
  logic r_vs_d, r_pv_d, r_req_d, r_rvalid, r_oob;
  cell_t r_code;
  logic w_pv_fall, w_line_wrap, w_ln_trig, w_vs_trig, w_trig, w_fetch, w_oob, w_buf_we;
  logic [CW-1:0] w_buf_wa;
  cell_t w_buf_rd;
  assign w_vs_trig = r_vs_d & ~bus.vsync;
  assign w_pv_fall = r_pv_d & ~bus.pix_valid;
  assign w_line_wrap = r_line == SW'(CELL_PX - 1);
  assign w_ln_trig = w_pv_fall & w_line_wrap & (r_row < RW'(GRID_H - 1));
  assign w_trig = w_vs_trig | w_ln_trig;
  assign w_fetch = r_state == FETCH;
  assign w_oob = bus.g_addr >= ADDR_W'(GRID_W * GRID_H);
  // RAM data lags its address by one cycle, so the buffer is written one slot behind k
  assign w_buf_we = (w_fetch & (r_k != '0)) | (r_state == DRAIN);
  assign w_buf_wa = w_fetch ? r_k - 1'b1 : CW'(GRID_W - 1);
  assign bus.g_gnt = (r_state == IDLE) & ~w_trig & bus.g_req & r_req_d;
  assign bus.ram_addr = w_fetch ? r_base + ADDR_W'(r_k) : bus.g_gnt ? bus.g_addr : '0;
  assign bus.ram_we = bus.g_gnt & bus.g_we & ~w_oob;
  assign bus.ram_wdata = bus.g_gnt ? bus.g_wdata : CELL_EMPTY;
  assign bus.g_rvalid = r_rvalid;
  assign bus.g_rdata = r_rvalid & ~r_oob ? bus.ram_rdata : CELL_EMPTY;
  assign bus.cell_code = r_code;
  assign bus.cell_valid = r_pv_d;
  snake_line_buf #(.DEPTH(GRID_W)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .i_we(w_buf_we),
    .i_waddr(w_buf_wa),
    .i_wdata(bus.ram_rdata),
    .i_raddr(r_col),
    .o_rdata(w_buf_rd)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_k <= '0;
      r_col <= '0;
      r_row <= '0;
      r_sub <= '0;
      r_line <= '0;
      r_base <= '0;
      r_vs_d <= 1'b0;
      r_pv_d <= 1'b0;
      r_req_d <= 1'b0;
      r_rvalid <= 1'b0;
      r_oob <= 1'b0;
      r_code <= CELL_EMPTY;
    end else begin
      r_vs_d <= bus.vsync;
      r_pv_d <= bus.pix_valid;
      r_req_d <= bus.g_req;
      r_rvalid <= bus.g_gnt & ~bus.g_we;
      r_oob <= w_oob;
      r_code <= bus.pix_valid ? w_buf_rd : CELL_EMPTY;
      r_sub <= ~bus.pix_valid || r_sub == SW'(CELL_PX - 1) ? '0 : r_sub + 1'b1;
      r_col <= ~bus.pix_valid ? '0 :
               r_sub == SW'(CELL_PX - 1) && r_col != CW'(GRID_W - 1) ? r_col + 1'b1 : r_col;
      if (w_pv_fall) r_line <= w_line_wrap ? '0 : r_line + 1'b1;
      if (w_ln_trig) begin
        r_row <= r_row + 1'b1;
        r_base <= r_base + ADDR_W'(GRID_W);
      end
      if (w_vs_trig) begin
        r_row <= '0;
        r_base <= '0;
        r_line <= '0;
      end
      if (w_trig) begin
        r_state <= FETCH;
        r_k <= '0;
      end else if (w_fetch) begin
        r_k <= r_k + 1'b1;
        if (r_k == CW'(GRID_W - 1)) r_state <= DRAIN;
      end else if (r_state == DRAIN) r_state <= IDLE;
    end
`ifdef GRID_BORDER_EN
  logic r_border;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_border <= 1'b0;
    else r_border <= bus.pix_valid & (r_col == '0 || r_col == CW'(GRID_W - 1) || r_row == '0 || r_row == RW'(GRID_H - 1));
  assign bus.pix_border = r_border;
`else
  assign bus.pix_border = 1'b0;
`endif
endmodule

// File: tb/tb_snake_grid_arbiter.sv
// tb_snake_grid_arbiter: table-driven game-port vectors plus scoreboarded display and read-data checks
module tb_snake_grid_arbiter;
  typedef struct {logic we; logic [10:0] addr; logic [1:0] wdata; logic exp_we; logic [1:0] exp_rd;} vec_t;
  typedef struct {logic [1:0] code; logic border;} disp_t;
  typedef struct {logic [1:0] data; int cyc;} rd_t;
  logic clk = 1'b0;
  logic rst_n;
  logic mem_clr;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int line_no = 0;
  logic [1:0] mem [2048];
  logic [1:0] exp_grid [1200];
  vec_t vec [16];
  disp_t disp_q [$];
  rd_t rd_q [$];
  snake_grid_arbiter_if bus ();
  snake_grid_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    if (mem_clr) begin
      foreach (mem[i]) mem[i] <= 2'd0;
      bus.ram_rdata <= 2'd0;
    end else begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr];
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic disp_t exp_pix(input int ln, input int p);
    disp_t d;
    int col, row;
    col = p / 20 > 39 ? 39 : p / 20;
    row = ln / 20;
    d.code = exp_grid[row * 40 + col];
`ifdef GRID_BORDER_EN
    d.border = col == 0 || col == 39 || row == 0 || row == 29;
`else
    d.border = 1'b0;
`endif
    return d;
  endfunction
  always @(negedge clk)
    if (bus.cell_valid) begin
      if (disp_q.size() == 0) chk("disp_unexpected_valid", 1, 0);
      else begin
        disp_t e;
        e = disp_q.pop_front();
        chk("cell_code", bus.cell_code, e.code);
        chk("pix_border", bus.pix_border, e.border);
      end
    end else begin
      chk("cell_code_idle", bus.cell_code, 0);
      chk("pix_border_idle", bus.pix_border, 0);
    end
  always @(negedge clk)
    if (bus.g_rvalid) begin
      if (rd_q.size() == 0) chk("rvalid_unexpected", 1, 0);
      else begin
        rd_t e;
        e = rd_q.pop_front();
        chk("g_rdata", bus.g_rdata, e.data);
        chk("rvalid_latency", cyc, e.cyc + 1);
      end
    end
  task automatic outputs_zero(input string tag);
    chk({tag, "_cell_code"}, bus.cell_code, 0);
    chk({tag, "_cell_valid"}, bus.cell_valid, 0);
    chk({tag, "_pix_border"}, bus.pix_border, 0);
    chk({tag, "_g_gnt"}, bus.g_gnt, 0);
    chk({tag, "_g_rvalid"}, bus.g_rvalid, 0);
    chk({tag, "_g_rdata"}, bus.g_rdata, 0);
    chk({tag, "_ram_we"}, bus.ram_we, 0);
    chk({tag, "_ram_addr"}, bus.ram_addr, 0);
    chk({tag, "_ram_wdata"}, bus.ram_wdata, 0);
  endtask
  task automatic run_vec(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      int t_gnt = -1;
      @(posedge clk); #1;
      bus.g_req = 1'b1;
      bus.g_we = vec[i].we;
      bus.g_addr = vec[i].addr;
      bus.g_wdata = vec[i].wdata;
      for (int t = 0; t < 100 && t_gnt < 0; t++) begin
        @(negedge clk);
        if (bus.g_gnt) begin
          t_gnt = t;
          chk("vec_ram_we", bus.ram_we, vec[i].exp_we);
          chk("vec_ram_addr", bus.ram_addr, vec[i].addr);
          if (!vec[i].we) rd_q.push_back('{vec[i].exp_rd, cyc});
          if (vec[i].exp_we) exp_grid[vec[i].addr] = vec[i].wdata;
        end
      end
      chk("vec_gnt_latency", t_gnt, i == lo ? 1 : 0);
    end
    @(posedge clk); #1;
    bus.g_req = 1'b0;
  endtask
  task automatic vsync_pulse();
    @(posedge clk); #1;
    bus.vsync = 1'b0;
    line_no = 0;
    @(posedge clk); #1;
    bus.vsync = 1'b1;
  endtask
  task automatic video_line(input int act, input bit probe);
    int gnt_b = -1;
    for (int p = 0; p < act; p++) begin
      @(posedge clk); #1;
      bus.pix_valid = 1'b1;
      disp_q.push_back(exp_pix(line_no, p));
    end
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
    if (probe) begin
      bus.g_req = 1'b1;
      bus.g_we = 1'b0;
      bus.g_addr = 11'd45;
    end
    for (int b = 0; b < 60; b++) begin
      @(negedge clk);
      if (probe && b == 1) chk("fetch_first_addr", bus.ram_addr, 40);
      if (probe && b == 40) chk("fetch_last_addr", bus.ram_addr, 79);
      if (probe && gnt_b < 0 && bus.g_gnt) begin
        gnt_b = b;
        rd_q.push_back('{exp_grid[45], cyc});
        @(posedge clk); #1;
        bus.g_req = 1'b0;
      end
    end
    if (probe) chk("fetch_then_gnt", gnt_b, 42);
    line_no++;
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int held_b;
    vec[0] = '{1'b1, 11'd0, 2'd3, 1'b1, 2'd0};
    vec[1] = '{1'b1, 11'd39, 2'd2, 1'b1, 2'd0};
    vec[2] = '{1'b1, 11'd45, 2'd1, 1'b1, 2'd0};
    vec[3] = '{1'b0, 11'd0, 2'd0, 1'b0, 2'd3};
    vec[4] = '{1'b0, 11'd39, 2'd0, 1'b0, 2'd2};
    vec[5] = '{1'b0, 11'd45, 2'd0, 1'b0, 2'd1};
    vec[6] = '{1'b0, 11'd45, 2'd0, 1'b0, 2'd2};
    vec[7] = '{1'b1, 11'd100, 2'd3, 1'b1, 2'd0};
    vec[8] = '{1'b0, 11'd100, 2'd0, 1'b0, 2'd3};
    vec[9] = '{1'b1, 11'd1199, 2'd1, 1'b1, 2'd0};
    vec[10] = '{1'b0, 11'd1199, 2'd0, 1'b0, 2'd1};
    vec[11] = '{1'b1, 11'd1200, 2'd3, 1'b0, 2'd0};
    vec[12] = '{1'b0, 11'd1200, 2'd0, 1'b0, 2'd0};
    vec[13] = '{1'b1, 11'd2047, 2'd2, 1'b0, 2'd0};
    vec[14] = '{1'b0, 11'd2047, 2'd0, 1'b0, 2'd0};
    vec[15] = '{1'b0, 11'd0, 2'd0, 1'b0, 2'd3};
    foreach (exp_grid[i]) exp_grid[i] = 2'd0;
    rst_n = 1'b0;
    mem_clr = 1'b1;
    bus.vsync = 1'b1;
    bus.pix_valid = 1'b0;
    bus.g_req = 1'b0;
    bus.g_we = 1'b0;
    bus.g_addr = '0;
    bus.g_wdata = '0;
    repeat (3) @(negedge clk);
    outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_clr = 1'b0;
    run_vec(0, 5);
    vsync_pulse();
    repeat (50) @(posedge clk);
    for (int l = 0; l <= 20; l++) video_line(800, l == 19);
    for (int l = 21; l < 300; l++) video_line(1, 1'b0);
    video_line(800, 1'b0);
    @(posedge clk); #1;
    bus.vsync = 1'b0;
    line_no = 0;
    bus.g_req = 1'b1;
    bus.g_we = 1'b1;
    bus.g_addr = 11'd45;
    bus.g_wdata = 2'd2;
    held_b = -1;
    for (int b = 0; b < 100 && held_b < 0; b++) begin
      @(negedge clk);
      if (bus.g_gnt) begin
        held_b = b;
        chk("held_ram_we", bus.ram_we, 1);
      end
      if (b == 0) begin
        @(posedge clk); #1;
        bus.vsync = 1'b1;
      end
    end
    chk("held_gnt_after_drain", held_b, 42);
    exp_grid[45] = 2'd2;
    @(posedge clk); #1;
    bus.g_req = 1'b0;
    run_vec(6, 14);
    vsync_pulse();
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    outputs_zero("midfetch_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_vec(15, 15);
    vsync_pulse();
    repeat (50) @(posedge clk);
    video_line(800, 1'b0);
    repeat (5) @(posedge clk);
    chk("disp_queue_drained", disp_q.size(), 0);
    chk("read_queue_drained", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
